// File: rtl/spi_master_link_if.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_master_link_if : control-loop handshake plus SPI pins
// Revision: 1.0
// ------------------------------------------------------------------
interface spi_master_link_if;
  logic        start;
  logic [15:0] pitch_pwm;
  logic [15:0] yaw_pwm;
  logic        busy;
  logic        done;
  logic [15:0] pitch_enc;
  logic [15:0] yaw_enc;
  logic        SPI_CLK;
  logic        SPI_PICO;
  logic        SPI_CS;
  logic        SPI_POCI;

  modport master (
    input  start, pitch_pwm, yaw_pwm, SPI_POCI,
    output busy, done, pitch_enc, yaw_enc, SPI_CLK, SPI_PICO, SPI_CS
  );

  modport slave (
    output start, pitch_pwm, yaw_pwm, SPI_POCI,
    input  busy, done, pitch_enc, yaw_enc, SPI_CLK, SPI_PICO, SPI_CS
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_link.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_master_link : SPI mode-0 master, 4 one-byte frames per start
// Revision: 1.0
// ------------------------------------------------------------------
module spi_master_link #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_link_if.master bus
);
  // A single down-counter times every phase, so it covers the longer of the two.
  localparam int               CNT_MAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int               CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       frame_q, frame_d;
  logic             high_q, high_d;
  logic [31:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [31:0]      rx_bytes_q, rx_bytes_d;
  logic [15:0]      pitch_enc_q, pitch_enc_d;
  logic [15:0]      yaw_enc_q, yaw_enc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             poci_s1_q, poci_s1_d;
  logic             poci_s2_q, poci_s2_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? cnt_q : cnt_q - CNT_ONE;
    bit_d       = bit_q;
    frame_d     = frame_q;
    high_d      = high_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rx_bytes_d  = rx_bytes_q;
    pitch_enc_d = pitch_enc_q;
    yaw_enc_d   = yaw_enc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    poci_s1_d   = bus.SPI_POCI;
    poci_s2_d   = poci_s1_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tx_d    = {bus.pitch_pwm, bus.yaw_pwm};
          frame_d = 2'd0;
          bit_d   = 3'd7;
          cnt_d   = DIV_LOAD;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = DIV_LOAD;
          high_d  = 1'b1;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], poci_s2_q};
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_zero) begin
          cnt_d = DIV_LOAD;
          if (high_q) begin
            // Falling edge: PICO always shows tx_q[31], so shifting presents the next bit.
            high_d = 1'b0;
            sclk_d = 1'b0;
            tx_d   = {tx_q[30:0], 1'b0};
          end else if (bit_q == 3'd0) begin
            state_d = S_CS_HOLD;
          end else begin
            bit_d  = bit_q - 3'd1;
            high_d = 1'b1;
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], poci_s2_q};
          end
        end
      end
      S_CS_HOLD: begin
        if (cnt_zero) begin
          cnt_d   = GAP_LOAD;
          cs_d    = 1'b1;
          state_d = S_GAP;
          case (frame_q)
            2'd0:    rx_bytes_d[31:24] = rx_q;
            2'd1:    rx_bytes_d[23:16] = rx_q;
            2'd2:    rx_bytes_d[15:8]  = rx_q;
            default: rx_bytes_d[7:0]   = rx_q;
          endcase
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          if (frame_q == 2'd3) begin
            pitch_enc_d = rx_bytes_q[31:16];
            yaw_enc_d   = rx_bytes_q[15:0];
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end else begin
            frame_d = frame_q + 2'd1;
            bit_d   = 3'd7;
            cnt_d   = DIV_LOAD;
            cs_d    = 1'b0;
            state_d = S_CS_SETUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      frame_q     <= 2'd0;
      high_q      <= 1'b0;
      tx_q        <= 32'd0;
      rx_q        <= 8'd0;
      rx_bytes_q  <= 32'd0;
      pitch_enc_q <= 16'd0;
      yaw_enc_q   <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      poci_s1_q   <= 1'b0;
      poci_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      high_q      <= high_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rx_bytes_q  <= rx_bytes_d;
      pitch_enc_q <= pitch_enc_d;
      yaw_enc_q   <= yaw_enc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      poci_s1_q   <= poci_s1_d;
      poci_s2_q   <= poci_s2_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pitch_enc = pitch_enc_q;
  assign bus.yaw_enc   = yaw_enc_q;
  assign bus.SPI_CLK   = sclk_q;
  assign bus.SPI_PICO  = tx_q[31];
  assign bus.SPI_CS    = cs_q;
endmodule
`default_nettype wire
